mfcc_frame_window: RTL and testbench

Parametrised framing and windowing stage for the MFCC front end. It multiplies each incoming audio sample by a run-time loadable, symmetric window coefficient and tracks sample and frame position. It applies round-half-up and saturation to a configurable output width, and supports valid/ready backpressure on both sides. It sits between the pre-emphasis stage and the FFT input buffer.

---
 rtl/mfcc_frame_window_if.sv | 28 ++
 rtl/mfcc_frame_window.sv | 152 +++++++++++++++
 tb/tb_mfcc_frame_window.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_frame_window_if.sv
// Streaming sample/output handshake bundle for the MFCC framing and windowing stage.
interface mfcc_frame_window_if #(
   parameter int unsigned IN_W  = 20,
   parameter int unsigned OUT_W = 24,
   parameter int unsigned CNT_W = 10,
   parameter int unsigned FRM_W = 16
);
   logic signed [IN_W-1:0]  in_data;
   logic                    in_valid;
   logic                    in_first;
   logic                    in_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [CNT_W-1:0]        out_idx;
   logic                    out_last;
   logic [FRM_W-1:0]        out_frame;

   modport master (
      output in_data, in_valid, in_first, out_ready,
      input  in_ready, out_data, out_valid, out_idx, out_last, out_frame
   );

   modport slave (
      input  in_data, in_valid, in_first, out_ready,
      output in_ready, out_data, out_valid, out_idx, out_last, out_frame
   );
endinterface

// File: rtl/mfcc_frame_window.sv
// Frames incoming audio samples and multiplies each one by a symmetric window coefficient.
// Three-stage pipeline: input/RAM read, multiply, round/saturate, with valid/ready backpressure.
module mfcc_frame_window #(
   parameter int unsigned IN_W      = 20,
   parameter int unsigned COEF_W    = 12,
   parameter int unsigned OUT_W     = 24,
   parameter int unsigned FRAME_LEN = 1024,
   parameter int unsigned CNT_W     = $clog2(FRAME_LEN),
   parameter int unsigned FRM_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   mfcc_frame_window_if.slave  bus,
   input  logic                win_en,
   input  logic                coef_we,
   input  logic [CNT_W-2:0]    coef_addr,
   input  logic [COEF_W:0]     coef_wdata,
   output logic                coef_err,
   output logic                busy
);
   localparam int unsigned HALF = FRAME_LEN / 2;
   localparam int unsigned P_W  = IN_W + COEF_W + 1;
   localparam int unsigned R_W  = P_W + 1;
   localparam int unsigned S    = IN_W + COEF_W - OUT_W;
   localparam logic [COEF_W:0]        UNITY = {1'b1, {COEF_W{1'b0}}};
   localparam logic signed [R_W-1:0]  BIAS  = R_W'(1) << (S - 1);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_nxt;

   logic                    adv_c, accept_c;
   logic [CNT_W-1:0]        n_q, n_nxt, idx_c;
   logic [FRM_W-1:0]        frm_q, frm_nxt, frm_smp_c;
   logic [CNT_W-2:0]        addr_c;
   logic                    s0_valid, s1_valid;
   logic                    s0_nxt, s1_nxt, out_nxt;

   logic signed [IN_W-1:0]  s0_data;
   logic [CNT_W-1:0]        s0_idx, s1_idx;
   logic [FRM_W-1:0]        s0_frm, s1_frm;
   logic                    s0_win;
   logic [COEF_W:0]         s0_coef, coef_c;
   logic signed [P_W-1:0]   a_ext_c, c_ext_c, prod_c, s1_prod;
   logic signed [R_W-1:0]   sum_c, shr_c;
   logic signed [OUT_W-1:0] sat_c;
   logic [R_W-OUT_W:0]      hi_c;

   logic [COEF_W:0] coef_ram [HALF];

   assign adv_c       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv_c;
   assign accept_c    = bus.in_valid && adv_c;
   assign busy        = (state_q == RUN);

   // Sample/frame position; in_first restarts the frame and abandons a partial one
   always_comb begin
      idx_c     = bus.in_first ? '0 : n_q;
      frm_smp_c = (bus.in_first && (n_q != '0)) ? frm_q + FRM_W'(1) : frm_q;
      n_nxt     = n_q;
      frm_nxt   = frm_q;
      if (accept_c) begin
         if (idx_c == CNT_W'(FRAME_LEN - 1)) begin
            n_nxt   = '0;
            frm_nxt = frm_smp_c + FRM_W'(1);
         end else begin
            n_nxt   = idx_c + CNT_W'(1);
            frm_nxt = frm_smp_c;
         end
      end
      addr_c = (idx_c < CNT_W'(HALF)) ? (CNT_W-1)'(idx_c)
                                      : (CNT_W-1)'(CNT_W'(FRAME_LEN - 1) - idx_c);
      s0_nxt  = adv_c ? accept_c : s0_valid;
      s1_nxt  = adv_c ? s0_valid : s1_valid;
      out_nxt = adv_c ? s1_valid : bus.out_valid;
   end

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: if (accept_c) state_nxt = RUN;
         RUN:  if ((n_nxt == '0) && !s0_nxt && !s1_nxt && !out_nxt) state_nxt = IDLE;
      endcase
   end

   // Multiply and round-half-up/saturate datapath
   always_comb begin
      coef_c  = s0_win ? s0_coef : UNITY;
      a_ext_c = P_W'(s0_data);
      c_ext_c = P_W'(coef_c);
      prod_c  = a_ext_c * c_ext_c;
      sum_c   = R_W'(s1_prod) + BIAS;
      shr_c   = sum_c >>> S;
      hi_c    = shr_c[R_W-1:OUT_W-1];
      if ((&hi_c) || !(|hi_c))
         sat_c = shr_c[OUT_W-1:0];
      else if (shr_c[R_W-1])
         sat_c = {1'b1, {(OUT_W-1){1'b0}}};
      else
         sat_c = {1'b0, {(OUT_W-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         n_q           <= '0;
         frm_q         <= '0;
         s0_valid      <= 1'b0;
         s1_valid      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_idx   <= '0;
         bus.out_last  <= 1'b0;
         bus.out_frame <= '0;
         coef_err      <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         n_q           <= n_nxt;
         frm_q         <= frm_nxt;
         s0_valid      <= s0_nxt;
         s1_valid      <= s1_nxt;
         bus.out_valid <= out_nxt;
         coef_err      <= coef_we && busy;
         if (adv_c && s1_valid) begin
            bus.out_data  <= sat_c;
            bus.out_idx   <= s1_idx;
            bus.out_last  <= (s1_idx == CNT_W'(FRAME_LEN - 1));
            bus.out_frame <= s1_frm;
         end
      end
   end

   // Stage payloads need no reset; their valids gate everything downstream
   always_ff @(posedge clk) begin
      if (accept_c) begin
         s0_data <= bus.in_data;
         s0_idx  <= idx_c;
         s0_frm  <= frm_smp_c;
         s0_win  <= win_en;
      end
      if (adv_c && s0_valid) begin
         s1_prod <= prod_c;
         s1_idx  <= s0_idx;
         s1_frm  <= s0_frm;
      end
   end

   // Coefficient RAM: read-before-write, contents survive reset
   always_ff @(posedge clk) begin
      if (coef_we && !busy) coef_ram[coef_addr] <= coef_wdata;
      if (accept_c) s0_coef <= coef_ram[addr_c];
   end
endmodule

// File: tb/tb_mfcc_frame_window.sv
// Directed plus randomized bench for mfcc_frame_window against an arithmetic reference model.
module tb_mfcc_frame_window;
   localparam int unsigned IN_W = 20, COEF_W = 12, OUT_W = 24, FRAME_LEN = 8, CNT_W = 3, FRM_W = 16;
   localparam int S = IN_W + COEF_W - OUT_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic win_en = 1'b0, coef_we = 1'b0;
   logic [CNT_W-2:0] coef_addr = '0;
   logic [COEF_W:0]  coef_wdata = '0;
   logic coef_err, busy;

   always #5 clk = ~clk;

   mfcc_frame_window_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();

   mfcc_frame_window #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN),
                       .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .win_en(win_en), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err), .busy(busy));

   typedef struct { longint data; int idx; bit last; int frame; } exp_t;
   exp_t   exp_q[$];
   int     n_checks = 0, n_fail = 0;
   int     m_n = 0, m_frame = 0;
   longint m_coef [FRAME_LEN/2] = '{default: 0};
   bit     m_err = 1'b0, m_ok = 1'b0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Windowed value from the arithmetic definition: floor((x*c + 2^(S-1)) / 2^S), then clamp
   function automatic longint ref_out(input longint x, input longint c);
      longint r, q, maxv;
      r = x * c + (longint'(1) << (S - 1));
      q = r / (longint'(1) << S);
      if (r < 0 && (r % (longint'(1) << S)) != 0) q = q - 1;
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      if (q > maxv) q = maxv;
      if (q < -maxv - 1) q = -maxv - 1;
      return q;
   endfunction

   function automatic longint rnd_sample();
      logic signed [IN_W-1:0] v;
      v = IN_W'($urandom);
      return longint'(v);
   endfunction

   // One clock: check/update the model at the falling edge, return just after the rising edge
   task automatic tick();
      bit acc, busy_m;
      int idx, addr;
      longint c;
      exp_t e;
      @(negedge clk);
      if (rst_n && m_ok) begin
         busy_m = (m_n != 0) || (exp_q.size() != 0);
         chk("busy", busy, busy_m);
         chk("coef_err", coef_err, m_err);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", bus.out_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_data", bus.out_data, e.data);
               chk("out_idx", bus.out_idx, e.idx);
               chk("out_last", bus.out_last, e.last);
               chk("out_frame", bus.out_frame, e.frame);
            end
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            idx = bus.in_first ? 0 : m_n;
            if (bus.in_first && m_n != 0) m_frame = (m_frame + 1) % 65536;
            addr = (idx < FRAME_LEN/2) ? idx : FRAME_LEN - 1 - idx;
            c = win_en ? m_coef[addr] : (longint'(1) << COEF_W);
            e.data = ref_out(longint'(bus.in_data), c);
            e.idx = idx; e.last = (idx == FRAME_LEN - 1); e.frame = m_frame;
            exp_q.push_back(e);
            m_n = idx + 1;
            if (m_n == FRAME_LEN) begin m_n = 0; m_frame = (m_frame + 1) % 65536; end
         end
         m_err = coef_we && busy_m;
         if (coef_we && !busy_m) m_coef[coef_addr] = longint'(coef_wdata);
      end else if (!rst_n) begin
         m_n = 0; m_frame = 0; exp_q.delete(); m_err = 1'b0; m_ok = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input longint d, input bit first);
      int guard = 0;
      bus.in_data = IN_W'(d); bus.in_first = first; bus.in_valid = 1'b1;
      while (!bus.in_ready && guard < 50) begin
         tick(); guard++;
         if (guard > 2) bus.out_ready = 1'b1;
      end
      if (guard >= 50) chk("in_ready_timeout", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0; bus.in_first = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wr(input int a, input int d);
      coef_we = 1'b1; coef_addr = (CNT_W-1)'(a); coef_wdata = (COEF_W+1)'(d);
      tick();
      coef_we = 1'b0;
   endtask

   task automatic check_reset();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_frame", bus.out_frame, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coef_err", coef_err, 0);
      chk("rst_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      int lat;
      logic signed [OUT_W-1:0] hd;
      logic [CNT_W-1:0] hi;
      logic [FRM_W-1:0] hf;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.out_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      check_reset();

      // Mirror addressing with a latency measurement on the first sample
      wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400);
      win_en = 1'b1;
      push(256, 1'b1);
      lat = 1;
      while (!bus.out_valid && lat < 10) begin tick(); lat++; end
      chk("latency", lat, 3);
      chk("mirror_first", bus.out_data, 100);
      for (int i = 1; i < 2 * FRAME_LEN; i++) push(256, 1'b0);
      idle(6);

      // Rectangular window, then random data/window/backpressure
      win_en = 1'b0;
      push(1000, 1'b0);
      push(-524288, 1'b0);
      for (int i = 0; i < 30; i++) begin
         win_en = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         push(rnd_sample(), ($urandom_range(0, 7) == 0));
      end
      bus.out_ready = 1'b1;
      while (m_n != 0) push(rnd_sample(), 1'b0);
      idle(6);

      // Rounding and saturation
      wr(0, 1); wr(1, 128); wr(2, 8191); wr(3, 8191);
      win_en = 1'b1;
      push(1, 1'b0); push(1, 1'b0); push(524287, 1'b0); push(-524288, 1'b0);
      push(-524288, 1'b0); push(524287, 1'b0); push(1, 1'b0); push(1, 1'b0);
      idle(6);

      // Backpressure: five stalled cycles mid-frame
      wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400);
      for (int i = 0; i < 4; i++) push(rnd_sample(), 1'b0);
      bus.in_data = IN_W'(rnd_sample()); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      #1;
      hd = bus.out_data; hi = bus.out_idx; hf = bus.out_frame;
      chk("stall_valid", bus.out_valid, 1);
      repeat (5) begin
         chk("stall_in_ready", bus.in_ready, 0);
         tick();
         chk("stall_data", bus.out_data, hd);
         chk("stall_idx", bus.out_idx, hi);
         chk("stall_frame", bus.out_frame, hf);
      end
      bus.out_ready = 1'b1;
      push(longint'(bus.in_data), 1'b0);
      for (int i = 0; i < 3; i++) push(rnd_sample(), 1'b0);
      idle(6);

      // Coefficient write while busy is dropped; same write while idle takes effect
      for (int i = 0; i < 3; i++) push(256, 1'b0);
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 555;
      push(256, 1'b0);
      coef_we = 1'b0;
      chk("coef_err_pulse", coef_err, 1);
      for (int i = 0; i < 4; i++) push(256, 1'b0);
      idle(6);
      wr(0, 555);
      for (int i = 0; i < FRAME_LEN; i++) push(256, 1'b0);
      idle(6);

      // Resync at n=5, then reset mid-frame
      for (int i = 0; i < 5; i++) push(rnd_sample(), 1'b0);
      push(256, 1'b1);
      for (int i = 0; i < 3; i++) push(256, 1'b0);
      rst_n = 1'b0; bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset();

      // Write and first sample in the same idle cycle, same address: old coefficient used
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 777;
      push(256, 1'b1);
      coef_we = 1'b0;
      for (int i = 1; i < FRAME_LEN; i++) push(256, 1'b0);
      idle(8);
      chk("drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
